accumulator_drain: RTL and testbench

//   Downstream stage of the accumulator bank. On Start, walks vectors 0..N-1 by driving

---
 rtl/accel_pkg.sv | 11 +
 rtl/requant_lane.sv | 43 ++++
 rtl/accumulator_drain.sv | 115 +++++++++++
 tb/tb_accumulator_drain.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/accel_pkg.sv
// Shared types for the accelerator datapath stages.
package accel_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      EMIT  = 2'd2,
      DONE  = 2'd3
   } drain_state_t;

endpackage

// File: rtl/requant_lane.sv
// One output lane: optional ReLU, round-half-up arithmetic right shift, signed saturation.
module requant_lane #(
   parameter int DATA_WIDTH  = 32,
   parameter int OUT_WIDTH   = 8,
   parameter int SHIFT_WIDTH = 5
) (
   input  logic [DATA_WIDTH-1:0]  acc,
   input  logic [SHIFT_WIDTH-1:0] shift,
   input  logic                   relu_en,
   output logic [OUT_WIDTH-1:0]   result
);

   localparam logic signed [DATA_WIDTH:0] SAT_HI = (DATA_WIDTH+1)'((1 << (OUT_WIDTH-1)) - 1);
   localparam logic signed [DATA_WIDTH:0] SAT_LO = -SAT_HI - (DATA_WIDTH+1)'(1);

   logic signed [DATA_WIDTH:0] x;
   logic signed [DATA_WIDTH:0] rnd;
   logic signed [DATA_WIDTH:0] r;

   // One extra bit of headroom keeps the rounding add from overflowing.
   always_comb begin
      x   = {acc[DATA_WIDTH-1], acc};
      rnd = '0;
      r   = '0;
      if (relu_en && acc[DATA_WIDTH-1]) begin
         x = '0;
      end
      if (shift == '0) begin
         r = x;
      end else begin
         rnd = (DATA_WIDTH+1)'(1) << (shift - SHIFT_WIDTH'(1));
         r   = (x + rnd) >>> shift;
      end
      if (r > SAT_HI) begin
         result = OUT_WIDTH'(SAT_HI);
      end else if (r < SAT_LO) begin
         result = OUT_WIDTH'(SAT_LO);
      end else begin
         result = r[OUT_WIDTH-1:0];
      end
   end

endmodule

// File: rtl/accumulator_drain.sv
// Walks the accumulator bank and streams requantised vectors toward the output buffer.
module accumulator_drain
   import accel_pkg::*;
#(
   parameter int VECTOR_WIDTH          = 3,
   parameter int NO_VECTORS            = 10,
   parameter int DATA_WIDTH            = 32,
   parameter int VECTOR_SELECTOR_WIDTH = 6,
   parameter int OUT_WIDTH             = 8,
   parameter int SHIFT_WIDTH           = 5
) (
   input  logic                               CLK,
   input  logic                               SYNC_RST,
   input  logic                               Start,
   input  logic [VECTOR_SELECTOR_WIDTH-1:0]   NumVectors,
   input  logic [SHIFT_WIDTH-1:0]             Shift,
   input  logic                               ReluEn,
   output logic [VECTOR_SELECTOR_WIDTH-1:0]   OutputVectorSelector,
   input  logic [DATA_WIDTH*VECTOR_WIDTH-1:0] AccResult,
   output logic [OUT_WIDTH*VECTOR_WIDTH-1:0]  OutData,
   output logic                               OutValid,
   input  logic                               OutReady,
   output logic                               OutLast,
   output logic                               Busy,
   output logic                               Done
);

   localparam logic [VECTOR_SELECTOR_WIDTH-1:0] MAX_COUNT = VECTOR_SELECTOR_WIDTH'(NO_VECTORS);
   localparam logic [VECTOR_SELECTOR_WIDTH-1:0] ONE       = VECTOR_SELECTOR_WIDTH'(1);

   drain_state_t                      state;
   logic [VECTOR_SELECTOR_WIDTH-1:0]  idx;
   logic [VECTOR_SELECTOR_WIDTH-1:0]  count;
   logic [VECTOR_SELECTOR_WIDTH-1:0]  n_clamped;
   logic [SHIFT_WIDTH-1:0]            shift_q;
   logic                              relu_q;
   logic [OUT_WIDTH*VECTOR_WIDTH-1:0] lane_out;

   assign n_clamped            = (NumVectors > MAX_COUNT) ? MAX_COUNT : NumVectors;
   assign OutputVectorSelector = idx;

   for (genvar i = 0; i < VECTOR_WIDTH; i++) begin : g_lane
      requant_lane #(
         .DATA_WIDTH (DATA_WIDTH),
         .OUT_WIDTH  (OUT_WIDTH),
         .SHIFT_WIDTH(SHIFT_WIDTH)
      ) u_lane (
         .acc    (AccResult[i*DATA_WIDTH +: DATA_WIDTH]),
         .shift  (shift_q),
         .relu_en(relu_q),
         .result (lane_out[i*OUT_WIDTH +: OUT_WIDTH])
      );
   end

   // The index doubles as the bank selector, so it stays put while EMIT waits.
   always_ff @(posedge CLK) begin
      if (SYNC_RST) begin
         state    <= IDLE;
         idx      <= '0;
         count    <= '0;
         shift_q  <= '0;
         relu_q   <= 1'b0;
         OutData  <= '0;
         OutValid <= 1'b0;
         OutLast  <= 1'b0;
         Busy     <= 1'b0;
         Done     <= 1'b0;
      end else begin
         Done <= 1'b0;
         case (state)
            IDLE: begin
               if (Start) begin
                  count   <= n_clamped;
                  shift_q <= Shift;
                  relu_q  <= ReluEn;
                  idx     <= '0;
                  if (n_clamped == '0) begin
                     state <= DONE;
                     Done  <= 1'b1;
                  end else begin
                     state <= FETCH;
                     Busy  <= 1'b1;
                  end
               end
            end
            FETCH: begin
               OutData  <= lane_out;
               OutLast  <= (idx == count - ONE);
               OutValid <= 1'b1;
               state    <= EMIT;
            end
            EMIT: begin
               if (OutReady) begin
                  OutValid <= 1'b0;
                  if (OutLast) begin
                     state <= DONE;
                     Busy  <= 1'b0;
                     Done  <= 1'b1;
                  end else begin
                     idx   <= idx + ONE;
                     state <= FETCH;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_accumulator_drain.sv
// Scoreboard bench for accumulator_drain against a small behavioural accumulator bank.
module tb_accumulator_drain;

   typedef struct packed {
      logic [23:0] data;
      logic        last;
      logic [5:0]  sel;
   } beat_t;

   logic        clk = 1'b0;
   logic        sync_rst = 1'b1;
   logic        start = 1'b0;
   logic [5:0]  num_vectors = '0;
   logic [4:0]  shift = '0;
   logic        relu_en = 1'b0;
   logic [5:0]  sel;
   logic [95:0] acc_result;
   logic [23:0] out_data;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic        out_last;
   logic        busy;
   logic        done;

   logic [95:0] acc_mem [10];
   beat_t       sb_q [$];
   beat_t       exp_beat;
   int          errors = 0;
   int          checks = 0;
   int          beats = 0;
   int          valid_cycles = 0;

   accumulator_drain dut (
      .CLK                 (clk),
      .SYNC_RST            (sync_rst),
      .Start               (start),
      .NumVectors          (num_vectors),
      .Shift               (shift),
      .ReluEn              (relu_en),
      .OutputVectorSelector(sel),
      .AccResult           (acc_result),
      .OutData             (out_data),
      .OutValid            (out_valid),
      .OutReady            (out_ready),
      .OutLast             (out_last),
      .Busy                (busy),
      .Done                (done)
   );

   always #5 clk = ~clk;

   assign acc_result = (sel < 6'd10) ? acc_mem[sel[3:0]] : '0;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic set_row(input int i, input int a, input int b, input int c);
      acc_mem[i] = {32'(c), 32'(b), 32'(a)};
   endtask

   function automatic logic [23:0] pack_out(input int a, input int b, input int c);
      return {8'(c), 8'(b), 8'(a)};
   endfunction

   task automatic expect_beat(input int s, input int a, input int b, input int c, input logic last);
      sb_q.push_back('{data: pack_out(a, b, c), last: last, sel: 6'(s)});
   endtask

   // Pulses Start, then scrambles the config inputs to prove the latched copies are used.
   task automatic applyStimulus(input int n, input int sh, input logic relu);
      @(posedge clk) #1;
      num_vectors = 6'(n);
      shift       = 5'(sh);
      relu_en     = relu;
      start       = 1'b1;
      @(posedge clk) #1;
      start       = 1'b0;
      num_vectors = 6'd7;
      shift       = 5'd3;
      relu_en     = ~relu;
   endtask

   task automatic wait_done(input int exp_beats, input int beats_before);
      bit found = 1'b0;
      for (int k = 0; k < 200 && !found; k++) begin
         @(negedge clk);
         if (done) found = 1'b1;
      end
      checkOutput("done_pulse", 32'(found), 32'd1);
      @(negedge clk);
      checkOutput("done_width", 32'(done), 32'd0);
      checkOutput("beat_count", 32'(beats - beats_before), 32'(exp_beats));
      checkOutput("sb_empty", 32'(sb_q.size()), 32'd0);
   endtask

   // Monitor: compares every accepted beat against the head of the scoreboard.
   always @(negedge clk) begin
      if (!sync_rst && out_valid) valid_cycles++;
      if (!sync_rst && out_valid && out_ready) begin
         beats++;
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_beat: got sel %0d data %0h, expected no beat", sel, out_data);
         end else begin
            exp_beat = sb_q.pop_front();
            checkOutput("beat_data", 32'(out_data), 32'(exp_beat.data));
            checkOutput("beat_last", 32'(out_last), 32'(exp_beat.last));
            checkOutput("beat_sel", 32'(sel), 32'(exp_beat.sel));
         end
      end
   end

   initial begin
      int b0;
      int v0;
      bit hit;
      for (int i = 0; i < 10; i++) acc_mem[i] = '0;

      repeat (3) @(posedge clk);
      #1 sync_rst = 1'b0;
      @(negedge clk);
      checkOutput("rst_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_done", 32'(done), 32'd0);
      checkOutput("rst_sel", 32'(sel), 32'd0);
      checkOutput("rst_data", 32'(out_data), 32'd0);

      $display("[TB] basic drain");
      set_row(0, 5, -3, 7);
      set_row(1, 1, 2, 3);
      set_row(2, 0, 0, -1);
      expect_beat(0, 5, -3, 7, 1'b0);
      expect_beat(1, 1, 2, 3, 1'b0);
      expect_beat(2, 0, 0, -1, 1'b1);
      b0 = beats;
      applyStimulus(3, 0, 1'b0);
      @(negedge clk);
      checkOutput("latency_fetch_valid", 32'(out_valid), 32'd0);
      checkOutput("latency_fetch_busy", 32'(busy), 32'd1);
      @(negedge clk);
      checkOutput("latency_emit_valid", 32'(out_valid), 32'd1);
      wait_done(3, b0);

      $display("[TB] saturation");
      set_row(0, 1000, -1000, 127);
      expect_beat(0, 127, -128, 127, 1'b1);
      b0 = beats;
      applyStimulus(1, 0, 1'b0);
      wait_done(1, b0);

      $display("[TB] rounding");
      set_row(0, 6, 5, -6);
      expect_beat(0, 2, 1, -1, 1'b1);
      b0 = beats;
      applyStimulus(1, 2, 1'b0);
      wait_done(1, b0);

      $display("[TB] relu on and off");
      set_row(0, -50, 50, -1);
      expect_beat(0, 0, 50, 0, 1'b1);
      b0 = beats;
      applyStimulus(1, 0, 1'b1);
      wait_done(1, b0);
      expect_beat(0, -50, 50, -1, 1'b1);
      b0 = beats;
      applyStimulus(1, 0, 1'b0);
      wait_done(1, b0);

      $display("[TB] backpressure");
      set_row(0, 10, 20, 30);
      set_row(1, -4, -5, -6);
      expect_beat(0, 10, 20, 30, 1'b0);
      expect_beat(1, -4, -5, -6, 1'b1);
      out_ready = 1'b0;
      b0 = beats;
      applyStimulus(2, 0, 1'b0);
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         checkOutput("stall_valid", 32'(out_valid), 32'd1);
         checkOutput("stall_data", 32'(out_data), 32'(pack_out(10, 20, 30)));
         checkOutput("stall_last", 32'(out_last), 32'd0);
         checkOutput("stall_sel", 32'(sel), 32'd0);
      end
      @(posedge clk) #1 out_ready = 1'b1;
      wait_done(2, b0);

      $display("[TB] zero vectors");
      v0 = valid_cycles;
      b0 = beats;
      applyStimulus(0, 0, 1'b0);
      checkOutput("zero_busy", 32'(busy), 32'd0);
      wait_done(0, b0);
      checkOutput("zero_no_valid", 32'(valid_cycles - v0), 32'd0);

      $display("[TB] clamped count");
      for (int i = 0; i < 10; i++) begin
         set_row(i, i, -i, 2 * i);
         expect_beat(i, i, -i, 2 * i, i == 9);
      end
      b0 = beats;
      applyStimulus(20, 0, 1'b0);
      wait_done(10, b0);

      $display("[TB] reset mid-drain");
      set_row(0, 5, -3, 7);
      set_row(1, 1, 2, 3);
      set_row(2, 0, 0, -1);
      expect_beat(0, 5, -3, 7, 1'b0);
      expect_beat(1, 1, 2, 3, 1'b0);
      expect_beat(2, 0, 0, -1, 1'b1);
      applyStimulus(3, 0, 1'b0);
      hit = 1'b0;
      for (int k = 0; k < 50 && !hit; k++) begin
         @(posedge clk) #1;
         if (out_valid && sel == 6'd1) hit = 1'b1;
      end
      checkOutput("reach_beat2", 32'(hit), 32'd1);
      out_ready = 1'b0;
      sync_rst  = 1'b1;
      @(posedge clk) #1;
      sync_rst  = 1'b0;
      checkOutput("abort_valid", 32'(out_valid), 32'd0);
      checkOutput("abort_busy", 32'(busy), 32'd0);
      checkOutput("abort_pending", 32'(sb_q.size()), 32'd2);
      sb_q.delete();
      @(negedge clk);
      checkOutput("abort_no_done", 32'(done), 32'd0);
      out_ready = 1'b1;
      expect_beat(0, 5, -3, 7, 1'b1);
      b0 = beats;
      applyStimulus(1, 0, 1'b0);
      wait_done(1, b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
